// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
//
// Load/store stage placed after the ALU. It accepts one op at a time. A
// non-memory op passes its ALU result through. A misaligned load/store
// reports the address with out_misaligned set and makes no memory access.
// An aligned load/store runs one request/grant/response transaction on the
// data-memory port. The write-back value is returned on a valid/ready
// handshake.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   in_valid        upstream op valid
//   in_ready        unit idle and able to accept an op
//   in_alucode      6-bit alucode (alucode_e below)
//   in_alu_result   ALU result; effective byte address for loads/stores
//   in_store_data   rs2 value for SB/SH/SW
//   mem_req         memory request, held until mem_gnt
//   mem_we          1 = write
//   mem_addr        word-aligned byte address (bits [1:0] = 0)
//   mem_be          byte enables
//   mem_wdata       store data replicated across lanes
//   mem_gnt         request accepted this cycle
//   mem_rvalid      read data valid
//   mem_rdata       read data
//   out_valid       write-back value available
//   out_ready       downstream accepts the value
//   out_data        write-back value
//   out_misaligned  op was misaligned and was not performed
// ============================================================================

package mem_access_pkg;

    // Alucode encodings. These match the ALU_* values in define.vh.
    typedef enum logic [5:0] {
        ALU_LUI  = 6'd0,
        ALU_JAL  = 6'd1,
        ALU_JALR = 6'd2,
        ALU_BEQ  = 6'd3,
        ALU_BNE  = 6'd4,
        ALU_BLT  = 6'd5,
        ALU_BGE  = 6'd6,
        ALU_BLTU = 6'd7,
        ALU_BGEU = 6'd8,
        ALU_LB   = 6'd9,
        ALU_LH   = 6'd10,
        ALU_LW   = 6'd11,
        ALU_LBU  = 6'd12,
        ALU_LHU  = 6'd13,
        ALU_SB   = 6'd14,
        ALU_SH   = 6'd15,
        ALU_SW   = 6'd16,
        ALU_ADD  = 6'd17,
        ALU_SUB  = 6'd18,
        ALU_XOR  = 6'd19,
        ALU_OR   = 6'd20,
        ALU_AND  = 6'd21,
        ALU_SLL  = 6'd22,
        ALU_SRL  = 6'd23,
        ALU_SRA  = 6'd24,
        ALU_SLT  = 6'd25,
        ALU_SLTU = 6'd26,
        ALU_NOP  = 6'd63
    } alucode_e;

endpackage

module mem_access_unit #(
    parameter int ADDR_W = 32   // byte-address width, at most 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_alucode,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_misaligned
);

    import mem_access_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e r_state;
    state_e w_next_state;

    // Registered op context.
    logic [5:0]        r_op;
    logic [1:0]        r_addr_lo;      // byte offset, selects the load lane
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_out_data;
    logic              r_misaligned;

    // ------------------------------------------------------------------------
    // Decode the incoming op.
    // ------------------------------------------------------------------------
    logic        w_in_load;
    logic        w_in_store;
    logic        w_in_misaligned;
    logic [3:0]  w_in_be;
    logic [31:0] w_in_wdata;
    logic [31:0] w_word_addr;

    assign w_word_addr = {in_alu_result[31:2], 2'b00};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so a path that assigns nothing cannot infer a latch.
        w_in_load       = 1'b0;
        w_in_store      = 1'b0;
        w_in_misaligned = 1'b0;
        w_in_be         = 4'b1111;
        w_in_wdata      = 32'h0;
        case (in_alucode)
            ALU_LB, ALU_LBU: begin
                w_in_load = 1'b1;
            end
            ALU_LH, ALU_LHU: begin
                w_in_load       = 1'b1;
                w_in_misaligned = in_alu_result[0];
            end
            ALU_LW: begin
                w_in_load       = 1'b1;
                w_in_misaligned = |in_alu_result[1:0];
            end
            ALU_SB: begin
                w_in_store = 1'b1;
                w_in_be    = 4'b0001 << in_alu_result[1:0];
                w_in_wdata = {4{in_store_data[7:0]}};
            end
            ALU_SH: begin
                w_in_store      = 1'b1;
                w_in_misaligned = in_alu_result[0];
                w_in_be         = 4'b0011 << in_alu_result[1:0];
                w_in_wdata      = {2{in_store_data[15:0]}};
            end
            ALU_SW: begin
                w_in_store      = 1'b1;
                w_in_misaligned = |in_alu_result[1:0];
                w_in_wdata      = in_store_data;
            end
            default: ;
        endcase
    end

    logic w_accept;
    logic w_mem_op_ok;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_mem_op_ok = (w_in_load || w_in_store) && !w_in_misaligned;

    // ------------------------------------------------------------------------
    // Memory response handling.
    // mem_gnt/mem_rvalid only matter in REQ/WAIT. An rvalid in REQ without
    // a grant is stray and is dropped.
    // ------------------------------------------------------------------------
    logic w_grant;
    logic w_store_done;
    logic w_load_resp;

    assign w_grant      = (r_state == S_REQ) && mem_gnt;
    assign w_store_done = w_grant && r_mem_we;
    assign w_load_resp  = (w_grant && !r_mem_we && mem_rvalid)
                       || ((r_state == S_WAIT) && mem_rvalid);

    // Shift the addressed lane down to bit 0, then extend it per load type.
    logic [31:0] w_lane;
    logic [31:0] w_load_val;

    assign w_lane = mem_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load_val = mem_rdata;
        case (r_op)
            ALU_LB:  w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
            ALU_LBU: w_load_val = {24'h0, w_lane[7:0]};
            ALU_LH:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
            ALU_LHU: w_load_val = {16'h0, w_lane[15:0]};
            default: w_load_val = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_mem_op_ok ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                // A load can finish in the grant cycle if rvalid comes with it.
                if (mem_gnt) begin
                    w_next_state = (r_mem_we || mem_rvalid) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers. The memory-port fields are loaded only when an
    // aligned memory op is accepted, so they stay stable through REQ.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= 6'h0;
            r_addr_lo    <= 2'b00;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= 32'h0;
            r_out_data   <= 32'h0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op         <= in_alucode;
                r_addr_lo    <= in_alu_result[1:0];
                r_misaligned <= w_in_misaligned;
                if (w_mem_op_ok) begin
                    r_mem_addr  <= ADDR_W'(w_word_addr);
                    r_mem_we    <= w_in_store;
                    r_mem_be    <= w_in_be;
                    r_mem_wdata <= w_in_wdata;
                end else begin
                    // Pass-through value, or the faulting address.
                    r_out_data <= in_alu_result;
                end
            end
            if (w_store_done) begin
                r_out_data <= 32'h0;
            end
            if (w_load_resp) begin
                r_out_data <= w_load_val;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready       = (r_state == S_IDLE);
    assign mem_req        = (r_state == S_REQ);
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_be         = r_mem_be;
    assign mem_wdata      = r_mem_wdata;
    assign out_valid      = (r_state == S_DONE);
    assign out_data       = r_out_data;
    assign out_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. A table of ops with hand-computed
// results drives the unit while the bench plays the memory: it grants after
// a scripted number of request cycles and returns read data after a scripted
// number of wait cycles. Hand-written sequences cover backpressure and reset
// in the middle of a transaction. Inputs change and outputs are sampled on
// the falling clock edge.
// ============================================================================
module tb_mem_access_unit;

    import mem_access_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_alucode;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_misaligned;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alucode     (in_alucode),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_misaligned (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"},       in_ready,       32'd1);
        check({tag, ".mem_req"},        mem_req,        32'd0);
        check({tag, ".mem_we"},         mem_we,         32'd0);
        check({tag, ".mem_addr"},       mem_addr,       32'd0);
        check({tag, ".mem_be"},         mem_be,         32'd0);
        check({tag, ".mem_wdata"},      mem_wdata,      32'd0);
        check({tag, ".out_valid"},      out_valid,      32'd0);
        check({tag, ".out_data"},       out_data,       32'd0);
        check({tag, ".out_misaligned"}, out_misaligned, 32'd0);
    endtask

    // One op: stimulus, memory behaviour and expected results.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gnt_wait;   // request cycles before the grant
        int          rv_wait;    // wait-state cycles before rvalid
        bit          rv_same;    // rvalid together with the grant
        bit          exp_req;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        bit          exp_mis;
        int          exp_lat;    // acceptance edge to out_valid, in cycles
    } vec_t;

    localparam int MAX_CYCLES = 20;

    task automatic run_op(input vec_t v, input string tag);
        int  c;
        int  r;
        int  w;
        int  req_cnt;
        bit  granted;
        bit  done;

        @(negedge clk);
        check({tag, ".in_ready"}, in_ready, 32'd1);
        in_valid      = 1'b1;
        in_alucode    = v.op;
        in_alu_result = v.addr;
        in_store_data = v.sdata;
        out_ready     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;

        c       = 1;
        r       = 0;
        w       = 0;
        req_cnt = 0;
        granted = 1'b0;
        done    = 1'b0;
        while (!done && c <= MAX_CYCLES) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            if (out_valid) begin
                done = 1'b1;
                check({tag, ".out_data"},       out_data,       v.exp_data);
                check({tag, ".out_misaligned"}, out_misaligned, 32'(v.exp_mis));
            end else begin
                if (mem_req) begin
                    req_cnt++;
                    check({tag, ".mem_addr"}, mem_addr, v.exp_addr);
                    check({tag, ".mem_we"},   mem_we,   32'(v.exp_we));
                    check({tag, ".mem_be"},   mem_be,   32'(v.exp_be));
                    if (v.exp_we) begin
                        check({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
                    end
                    if (r == v.gnt_wait) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                        if (v.rv_same) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = v.rdata;
                        end
                    end else if (!v.exp_we) begin
                        // Stray read response before the grant.
                        mem_rvalid = 1'b1;
                        mem_rdata  = 32'hDEAD_BEEF;
                    end
                    r++;
                end else if (granted) begin
                    if (w == v.rv_wait) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                    w++;
                end
                @(negedge clk);
                c++;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check({tag, ".latency"}, c, v.exp_lat);
        check({tag, ".req_cycles"}, req_cnt, v.exp_req ? v.gnt_wait + 1 : 0);

        // With out_ready already high, DONE lasts exactly one cycle.
        @(negedge clk);
        check({tag, ".valid_drop"}, out_valid, 32'd0);
        check({tag, ".ready_back"}, in_ready,  32'd1);
    endtask

    vec_t vecs[15];

    initial begin
        // op       addr          sdata         rdata         gw rw same req we exp_addr      be       wdata         data          mis lat
        vecs[0]  = '{ALU_ADD, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h1234_5678, 0, 1};
        vecs[1]  = '{ALU_SB,  32'h0000_0103, 32'hAABB_CCDD, 32'h0,       2, 0, 0, 1, 1, 32'h100, 4'b1000, 32'hDDDD_DDDD, 32'h0,        0, 4};
        vecs[2]  = '{ALU_LB,  32'h0000_0202, 32'h0,        32'h0080_0000, 0, 0, 0, 1, 0, 32'h200, 4'b1111, 32'h0,        32'hFFFF_FF80, 0, 3};
        vecs[3]  = '{ALU_LBU, 32'h0000_0202, 32'h0,        32'h0080_0000, 0, 0, 0, 1, 0, 32'h200, 4'b1111, 32'h0,        32'h0000_0080, 0, 3};
        vecs[4]  = '{ALU_LHU, 32'h0000_0202, 32'h0,        32'hBEEF_0000, 0, 0, 1, 1, 0, 32'h200, 4'b1111, 32'h0,        32'h0000_BEEF, 0, 2};
        vecs[5]  = '{ALU_LW,  32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0000_0006, 1, 1};
        vecs[6]  = '{ALU_SH,  32'h0000_0101, 32'h0000_1234, 32'h0,       0, 0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0000_0101, 1, 1};
        vecs[7]  = '{ALU_SW,  32'h0000_0008, 32'h0123_4567, 32'h0,       0, 0, 0, 1, 1, 32'h8,   4'b1111, 32'h0123_4567, 32'h0,        0, 2};
        vecs[8]  = '{ALU_SH,  32'h0000_0102, 32'h1234_ABCD, 32'h0,       0, 0, 0, 1, 1, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 2};
        vecs[9]  = '{ALU_LH,  32'h0000_0000, 32'h0,        32'h0000_8001, 0, 0, 1, 1, 0, 32'h0,   4'b1111, 32'h0,        32'hFFFF_8001, 0, 2};
        vecs[10] = '{ALU_LW,  32'h0000_0010, 32'h0,        32'hCAFE_F00D, 1, 1, 0, 1, 0, 32'h10,  4'b1111, 32'h0,        32'hCAFE_F00D, 0, 5};
        vecs[11] = '{ALU_LB,  32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 1, 1, 0, 32'h0,   4'b1111, 32'h0,        32'h0000_007F, 0, 2};
        vecs[12] = '{ALU_XOR, 32'hFFFF_FFFF, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'hFFFF_FFFF, 0, 1};
        vecs[13] = '{ALU_LHU, 32'h0000_0203, 32'h0,        32'h0,        0, 0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0000_0203, 1, 1};
        vecs[14] = '{ALU_LH,  32'h0000_0002, 32'h0,        32'h7FFF_0000, 0, 2, 0, 1, 0, 32'h0,   4'b1111, 32'h0,        32'h0000_7FFF, 0, 5};

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_alucode    = 6'd0;
        in_alu_result = 32'h0;
        in_store_data = 32'h0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        out_ready     = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // ---------------- Table-driven ops ----------------
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // ---------------- Backpressure in DONE ----------------
        @(negedge clk);
        check("bp.in_ready", in_ready, 32'd1);
        in_valid      = 1'b1;
        in_alucode    = ALU_SUB;
        in_alu_result = 32'h0BAD_F00D;
        out_ready     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.valid", out_valid, 32'd1);
        check("bp.data",  out_data,  32'h0BAD_F00D);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp.hold%0d.valid", k),    out_valid, 32'd1);
            check($sformatf("bp.hold%0d.data", k),     out_data,  32'h0BAD_F00D);
            check($sformatf("bp.hold%0d.in_ready", k), in_ready,  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.release.valid",    out_valid, 32'd0);
        check("bp.release.in_ready", in_ready,  32'd1);

        // ---------------- Reset while in REQ ----------------
        in_valid      = 1'b1;
        in_alucode    = ALU_SW;
        in_alu_result = 32'h0000_0040;
        in_store_data = 32'h7777_8888;
        @(negedge clk);
        in_valid = 1'b0;
        check("rreq.mem_req", mem_req, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("rreq");

        // ---------------- Reset while in WAIT, late rvalid ----------------
        @(negedge clk);
        in_valid      = 1'b1;
        in_alucode    = ALU_LW;
        in_alu_result = 32'h0000_0300;
        @(negedge clk);
        in_valid = 1'b0;
        check("rwait.mem_req", mem_req, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rwait.in_wait.mem_req",   mem_req,   32'd0);
        check("rwait.in_wait.out_valid", out_valid, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_vals("rwait");
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rwait.late.out_valid", out_valid, 32'd0);
        check("rwait.late.in_ready",  in_ready,  32'd1);
        check("rwait.late.out_data",  out_data,  32'd0);
        @(negedge clk);
        check("rwait.late2.out_valid", out_valid, 32'd0);

        // The next op after the reset completes normally.
        run_op(vecs[3], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
